int_ctrl: RTL and testbench
===========================

# int_ctrl

Interrupt controller between the P7 CPU's CP0 and the peripheral devices (timers, I/O) behind the system bridge. It captures rising edges on the device interrupt lines into pending bits and applies a software mask and a global enable. It presents one prioritised, non-nesting request at a time to CP0 with an acknowledge/return handshake. Its four registers are memory-mapped through the bridge.

## Interface
- NUM_SRC, 6: number of device interrupt lines, 1..8.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 resets all state immediately.
- irq_in  in  NUM_SRC  raw device interrupt lines, level. Bit 0 has the highest priority.
- we  in  1  bus write strobe from the bridge.
- addr  in  2  register word index: 0 PEND, 1 MASK, 2 STAT, 3 CTRL.
- wdata  in  32  bus write data.
- rdata  out  32  combinational read of the register at addr; unused bits read 0.
- int_req  out  1  registered interrupt request to CP0.
- int_id  out  3  registered index of the requested or in-service source.
- int_ack  in  1  one-cycle pulse from CP0 on exception entry.
- eret  in  1  one-cycle pulse from CP0 on ERET.

## Operation
- Edge detect:
  - prev[NUM_SRC] holds irq_in from the previous cycle.
  - rise = irq_in & ~prev.
  - A rise sets the matching pend bit.
- Registers:
  - PEND (RO + write-1-to-clear): pend[NUM_SRC-1:0].
  - MASK (RW): mask[NUM_SRC-1:0]. A 1 enables the source.
  - STAT (RO): bit 4 = in_service, bit 3 = int_req, bits 2:0 = int_id.
  - CTRL (RW): bit 0 = gie.
  - Writes to STAT are ignored.
- Per-bit pend update priority, highest first: rise sets > ack clear > W1C clear. If a rise and a clear hit the same bit in one cycle, the bit ends at 1.
- eligible = pend & mask, qualified by gie. sel = lowest-index set bit of eligible.
- FSM (state reg, 2 bits):
  - IDLE:
    - If eligible ≠ 0, go to REQ, set int_id ← sel and int_req ← 1.
    - int_ack and eret are ignored.
  - REQ:
    - On int_ack: clear pend[int_id], set int_req ← 0, go to SERVICE.
    - Otherwise, if pend[int_id] = 0, mask[int_id] = 0 or gie = 0, withdraw: int_req ← 0, go to IDLE.
    - int_ack takes precedence over withdrawal in the same cycle.
    - int_id stays frozen while in REQ, even if a higher-priority source becomes pending.
  - SERVICE:
    - in_service = 1 and int_id is held.
    - No new request is issued, so there is no nesting.
    - On eret, go to IDLE.
    - int_ack is ignored.
- Pending edges keep accumulating in every state. A higher-priority source pending at eret is served next.
- NUM_SRC < 8: int_id is zero-extended, and upper wdata bits of PEND and MASK are ignored.

## Timing
- Reset values:
  - pend = 0, mask = 0, gie = 0, prev = 0.
  - state = IDLE, int_req = 0, int_id = 0.
  - rdata follows the reset registers.
- Request latency:
  - irq_in rises before edge t, so pend is set at t.
  - If eligible, int_req = 1 after edge t+1, a 2-cycle latency.
  - If the line is already pending and mask or gie is then enabled by a write at edge t, int_req = 1 after t+1.
- Ack: int_ack sampled at edge t gives int_req = 0 and pend[int_id] = 0 after t.
- Return: eret at edge t gives IDLE after t. A still-eligible source raises int_req after t+1.
- Register writes take effect at the edge where we = 1. rdata reflects them in the following cycle.
- A level held high sets pend only once. A new rise requires irq_in to go low for at least one cycle.
- reset asserted mid-handshake: int_req drops to 0 asynchronously, all pending is lost, and CP0 sees no ack obligation.

## Test plan
- Basic: mask = 6'h3F, gie = 1; pulse irq_in[3] → int_req = 1 two edges later, int_id = 3, PEND = 0x08. int_ack → PEND = 0, int_req = 0, STAT = 0x13. eret → STAT = 0x03.
- Priority: raise irq_in[5] and irq_in[1] in the same cycle → int_id = 1 first. After ack and eret → int_id = 5.
- No nesting: in SERVICE (id 4), pulse irq_in[0] → int_req stays 0 until eret. One cycle after eret → int_req = 1, int_id = 0.
- Withdraw: in REQ (id 2), write MASK = 0x3B → int_req = 0 next cycle, state IDLE, PEND still 0x04. Write MASK = 0x3F → request reissued, int_id = 2.
- Set-over-clear: a W1C write of PEND = 0x01 in the same cycle as a rise on irq_in[0] → PEND bit 0 = 1.
- Reset mid-operation: drive reset = 0 while int_req = 1 → int_req = 0, PEND, MASK and CTRL all 0 without waiting for a clock edge. After release, a held-high irq_in does not set pend until it toggles.

Source files
------------

// File: rtl/int_ctrl.sv
// Interrupt controller for the P7 CP0: rising-edge capture, mask and global
// enable, one prioritised non-nesting request with ack/eret handshake.
module int_ctrl #(
    parameter int NUM_SRC = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               we,
    input  logic [1:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               int_req,
    output logic [2:0]         int_id,
    input  logic               int_ack,
    input  logic               eret
);

    // state   | meaning
    // IDLE    | no request outstanding, looking for an eligible source
    // REQ     | int_req high, int_id frozen, waiting for int_ack
    // SERVICE | handler running, no new request until eret
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] prev_q, prev_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic               gie_q, gie_d;
    logic               armed_q, armed_d;
    logic               int_req_q, int_req_d;
    logic [2:0]         int_id_q, int_id_d;

    logic [NUM_SRC-1:0] rise, eligible, id_onehot, ack_clr, w1c_clr;
    logic [2:0]         sel;
    logic               id_live, in_service;
    logic               wr_pend, wr_mask, wr_ctrl;
    logic [31:0]        unused_wdata;

    assign unused_wdata = wdata;

    always_comb begin
        wr_pend = we && (addr == 2'd0);
        wr_mask = we && (addr == 2'd1);
        wr_ctrl = we && (addr == 2'd3);
        w1c_clr = wr_pend ? wdata[NUM_SRC-1:0] : '0;

        // The first edge after reset only samples irq_in, so a line already
        // high when reset is released does not look like a fresh rise.
        rise      = armed_q ? (irq_in & ~prev_q) : '0;
        eligible  = gie_q ? (pend_q & mask_q) : '0;
        id_onehot = NUM_SRC'(1) << int_id_q;
        id_live   = gie_q && (|(pend_q & mask_q & id_onehot));

        sel = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) sel = 3'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        int_req_d = int_req_q;
        int_id_d  = int_id_q;
        ack_clr   = '0;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d   = REQ;
                    int_req_d = 1'b1;
                    int_id_d  = sel;
                end
            end
            REQ: begin
                if (int_ack) begin
                    ack_clr   = id_onehot;
                    int_req_d = 1'b0;
                    state_d   = SERVICE;
                end else if (!id_live) begin
                    int_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            SERVICE: begin
                if (eret) state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                int_req_d = 1'b0;
            end
        endcase

        // A rise in the same cycle as any clear wins.
        pend_d  = (pend_q & ~w1c_clr & ~ack_clr) | rise;
        prev_d  = irq_in;
        armed_d = 1'b1;
        mask_d  = wr_mask ? wdata[NUM_SRC-1:0] : mask_q;
        gie_d   = wr_ctrl ? wdata[0] : gie_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            gie_q     <= 1'b0;
            armed_q   <= 1'b0;
            int_req_q <= 1'b0;
            int_id_q  <= 3'd0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            gie_q     <= gie_d;
            armed_q   <= armed_d;
            int_req_q <= int_req_d;
            int_id_q  <= int_id_d;
        end
    end

    assign in_service = (state_q == SERVICE);

    always_comb begin
        rdata = 32'd0;
        case (addr)
            2'd0: rdata = 32'(pend_q);
            2'd1: rdata = 32'(mask_q);
            2'd2: rdata = {27'd0, in_service, int_req_q, int_id_q};
            2'd3: rdata = {31'd0, gie_q};
            default: rdata = 32'd0;
        endcase
    end

    assign int_req = int_req_q;
    assign int_id  = int_id_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: handshake, priority, no nesting, withdrawal,
// set-over-clear and asynchronous reset behaviour.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  irq_in;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        int_req;
    logic [2:0]  int_id;
    logic        int_ack;
    logic        eret;

    int passed = 0;
    int total  = 0;

    int_ctrl #(.NUM_SRC(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .int_req (int_req),
        .int_id  (int_id),
        .int_ack (int_ack),
        .eret    (eret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0; wdata = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a);
        addr = a;
        #1;
    endtask

    task automatic pulse(input logic [5:0] bits);
        irq_in = bits;
        tick();
        irq_in = 6'd0;
    endtask

    task automatic do_ack();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
    endtask

    task automatic do_eret();
        eret = 1'b1; tick(); eret = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; irq_in = 6'd0; we = 1'b0; addr = 2'd0; wdata = 32'd0;
        int_ack = 1'b0; eret = 1'b0;
        #23;
        total++; if (int_req !== 1'b0) $display("FAIL reset_int_req: got %b expected 0", int_req); else passed++;
        total++; if (int_id !== 3'd0) $display("FAIL reset_int_id: got %0d expected 0", int_id); else passed++;
        reset = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            total++; if (rdata !== 32'd0) $display("FAIL reset_reg%0d: got %h expected 00000000", a, rdata); else passed++;
        end
    endtask

    task automatic test_basic();
        wr(2'd1, 32'hFFFF_FF3F);
        wr(2'd3, 32'd1);
        rd(2'd1);
        total++; if (rdata !== 32'h3F) $display("FAIL mask_rd: got %h expected 0000003f", rdata); else passed++;
        rd(2'd3);
        total++; if (rdata !== 32'h1) $display("FAIL ctrl_rd: got %h expected 00000001", rdata); else passed++;
        pulse(6'h08);
        total++; if (int_req !== 1'b0) $display("FAIL basic_latency1: got %b expected 0", int_req); else passed++;
        tick();
        total++; if (int_req !== 1'b1) $display("FAIL basic_req: got %b expected 1", int_req); else passed++;
        total++; if (int_id !== 3'd3) $display("FAIL basic_id: got %0d expected 3", int_id); else passed++;
        rd(2'd0);
        total++; if (rdata !== 32'h08) $display("FAIL basic_pend: got %h expected 00000008", rdata); else passed++;
        do_ack();
        rd(2'd0);
        total++; if (rdata !== 32'h0) $display("FAIL basic_pend_ack: got %h expected 00000000", rdata); else passed++;
        total++; if (int_req !== 1'b0) $display("FAIL basic_req_ack: got %b expected 0", int_req); else passed++;
        rd(2'd2);
        total++; if (rdata !== 32'h13) $display("FAIL basic_stat_svc: got %h expected 00000013", rdata); else passed++;
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2);
        total++; if (rdata !== 32'h13) $display("FAIL stat_write_ignored: got %h expected 00000013", rdata); else passed++;
        do_ack();
        rd(2'd2);
        total++; if (rdata !== 32'h13) $display("FAIL ack_in_service_ignored: got %h expected 00000013", rdata); else passed++;
        do_eret();
        rd(2'd2);
        total++; if (rdata !== 32'h03) $display("FAIL basic_stat_eret: got %h expected 00000003", rdata); else passed++;
    endtask

    task automatic test_priority();
        pulse(6'h22);
        tick();
        total++; if (int_id !== 3'd1 || int_req !== 1'b1) $display("FAIL prio_first: got id %0d req %b expected id 1 req 1", int_id, int_req); else passed++;
        do_ack();
        rd(2'd0);
        total++; if (rdata !== 32'h20) $display("FAIL prio_pend: got %h expected 00000020", rdata); else passed++;
        do_eret();
        tick();
        total++; if (int_id !== 3'd5 || int_req !== 1'b1) $display("FAIL prio_second: got id %0d req %b expected id 5 req 1", int_id, int_req); else passed++;
        do_ack();
        do_eret();
    endtask

    task automatic test_no_nesting();
        pulse(6'h10);
        tick();
        do_ack();
        pulse(6'h01);
        tick();
        tick();
        total++; if (int_req !== 1'b0) $display("FAIL nest_req_in_svc: got %b expected 0", int_req); else passed++;
        rd(2'd2);
        total++; if (rdata !== 32'h14) $display("FAIL nest_stat: got %h expected 00000014", rdata); else passed++;
        do_eret();
        total++; if (int_req !== 1'b0) $display("FAIL nest_req_at_eret: got %b expected 0", int_req); else passed++;
        tick();
        total++; if (int_req !== 1'b1 || int_id !== 3'd0) $display("FAIL nest_after_eret: got req %b id %0d expected req 1 id 0", int_req, int_id); else passed++;
        do_ack();
        do_eret();
    endtask

    task automatic test_withdraw();
        pulse(6'h04);
        tick();
        total++; if (int_req !== 1'b1 || int_id !== 3'd2) $display("FAIL wd_req: got req %b id %0d expected req 1 id 2", int_req, int_id); else passed++;
        wr(2'd1, 32'h3B);
        tick();
        total++; if (int_req !== 1'b0) $display("FAIL wd_dropped: got %b expected 0", int_req); else passed++;
        rd(2'd2);
        total++; if (rdata !== 32'h02) $display("FAIL wd_stat: got %h expected 00000002", rdata); else passed++;
        rd(2'd0);
        total++; if (rdata !== 32'h04) $display("FAIL wd_pend: got %h expected 00000004", rdata); else passed++;
        wr(2'd1, 32'h3F);
        tick();
        total++; if (int_req !== 1'b1 || int_id !== 3'd2) $display("FAIL wd_reissue: got req %b id %0d expected req 1 id 2", int_req, int_id); else passed++;
        wr(2'd3, 32'd0);
        tick();
        total++; if (int_req !== 1'b0) $display("FAIL wd_gie: got %b expected 0", int_req); else passed++;
        wr(2'd0, 32'h04);
        wr(2'd3, 32'd1);
    endtask

    task automatic test_set_over_clear();
        irq_in = 6'h01;
        we = 1'b1; addr = 2'd0; wdata = 32'h01;
        tick();
        we = 1'b0; irq_in = 6'h00;
        rd(2'd0);
        total++; if (rdata !== 32'h01) $display("FAIL soc_pend: got %h expected 00000001", rdata); else passed++;
        wr(2'd0, 32'h01);
        rd(2'd0);
        total++; if (rdata !== 32'h00) $display("FAIL w1c_pend: got %h expected 00000000", rdata); else passed++;
        total++; if (int_req !== 1'b1) $display("FAIL w1c_req: got %b expected 1", int_req); else passed++;
        tick();
        total++; if (int_req !== 1'b0) $display("FAIL w1c_withdraw: got %b expected 0", int_req); else passed++;
    endtask

    task automatic test_reset_mid();
        pulse(6'h02);
        tick();
        total++; if (int_req !== 1'b1) $display("FAIL rst_pre_req: got %b expected 1", int_req); else passed++;
        irq_in = 6'h02;
        #1;
        reset = 1'b0;
        #1;
        total++; if (int_req !== 1'b0) $display("FAIL rst_async_req: got %b expected 0", int_req); else passed++;
        rd(2'd0);
        total++; if (rdata !== 32'h0) $display("FAIL rst_async_pend: got %h expected 00000000", rdata); else passed++;
        rd(2'd1);
        total++; if (rdata !== 32'h0) $display("FAIL rst_async_mask: got %h expected 00000000", rdata); else passed++;
        rd(2'd3);
        total++; if (rdata !== 32'h0) $display("FAIL rst_async_ctrl: got %h expected 00000000", rdata); else passed++;
        tick();
        reset = 1'b1;
        tick();
        tick();
        tick();
        rd(2'd0);
        total++; if (rdata !== 32'h0) $display("FAIL rst_held_level: got %h expected 00000000", rdata); else passed++;
        irq_in = 6'h00;
        tick();
        irq_in = 6'h02;
        tick();
        tick();
        rd(2'd0);
        total++; if (rdata !== 32'h02) $display("FAIL rst_retoggle: got %h expected 00000002", rdata); else passed++;
        tick();
        tick();
        rd(2'd0);
        total++; if (rdata !== 32'h02) $display("FAIL level_once: got %h expected 00000002", rdata); else passed++;
        wr(2'd0, 32'h02);
        rd(2'd0);
        total++; if (rdata !== 32'h00) $display("FAIL level_no_reset: got %h expected 00000000", rdata); else passed++;
        irq_in = 6'h00;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_no_nesting();
        test_withdraw();
        test_set_over_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
